// File: rtl/pipelined_decoder.sv
// Registered valid/ready pico-MIPS decoder with multi-cycle MULT stall.
// Optional illegal-opcode trap: define ILLEGAL_OP_TRAP_EN.
`ifndef RADD
`define RADD 3'd2
`endif
`ifndef RSUB
`define RSUB 3'd3
`endif
`ifndef ADD
`define ADD  6'd1
`define SUB  6'd2
`define ADDI 6'd3
`define SUBI 6'd4
`define BEQ  6'd5
`define BNQ  6'd6
`define JMP  6'd7
`define MULT 6'd8
`define STIN 6'd9
`define LOUT 6'd10
`endif

module pipelined_decoder #(
  parameter int OPCODE_W     = 6,
  parameter int ALU_FUNC_W   = 3,
  parameter int MULT_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic                  ZF,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ALU_FUNC_W-1:0] alu_func,
  output logic                  pc_rel_branch,
  output logic                  reg_write,
  output logic                  immediate,
  output logic                  mult,
  output logic                  read_in,
  output logic                  write_out,
  output logic                  illegal
);

  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(`ADD);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(`SUB);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(`ADDI);
  localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(`SUBI);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(`BEQ);
  localparam logic [OPCODE_W-1:0] OP_BNQ  = OPCODE_W'(`BNQ);
  localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(`JMP);
  localparam logic [OPCODE_W-1:0] OP_MULT = OPCODE_W'(`MULT);
  localparam logic [OPCODE_W-1:0] OP_STIN = OPCODE_W'(`STIN);
  localparam logic [OPCODE_W-1:0] OP_LOUT = OPCODE_W'(`LOUT);

  localparam logic [ALU_FUNC_W-1:0] F_ADD = ALU_FUNC_W'(`RADD);
  localparam logic [ALU_FUNC_W-1:0] F_SUB = ALU_FUNC_W'(`RSUB);

  localparam logic [3:0] CNT_LOAD = 4'(MULT_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    MULT_WAIT
  } state_t;

  typedef struct packed {
    logic [ALU_FUNC_W-1:0] alu_func;
    logic                  pc_rel_branch;
    logic                  reg_write;
    logic                  immediate;
    logic                  mult;
    logic                  read_in;
    logic                  write_out;
    logic                  illegal;
  } ctrl_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  ctrl_t      word_q, word_d;
  ctrl_t      dec, mult_word;
  logic       accept, is_mult;

  assign out_valid = (state_q == ISSUE);
  assign in_ready  = (state_q != MULT_WAIT) &
                     (!out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign is_mult   = (opcode == OP_MULT);

  always_comb begin
    mult_word           = '0;
    mult_word.mult      = 1'b1;
    mult_word.reg_write = 1'b1;
  end

  always_comb begin
    dec = '0;
    unique case (1'b1)
      (opcode == OP_ADD),
      (opcode == OP_ADDI): begin
        dec.alu_func  = F_ADD;
        dec.reg_write = 1'b1;
        dec.immediate = (opcode == OP_ADDI);
      end
      (opcode == OP_SUB),
      (opcode == OP_SUBI): begin
        dec.alu_func  = F_SUB;
        dec.reg_write = 1'b1;
        dec.immediate = (opcode == OP_SUBI);
      end
      (opcode == OP_BEQ): dec.pc_rel_branch = ZF;
      (opcode == OP_BNQ): dec.pc_rel_branch = !ZF;
      (opcode == OP_JMP): dec.pc_rel_branch = 1'b1;
      (opcode == OP_MULT): dec = mult_word;
      (opcode == OP_STIN): begin
        dec.read_in   = 1'b1;
        dec.reg_write = 1'b1;
      end
      (opcode == OP_LOUT): dec.write_out = 1'b1;
      default: begin
`ifdef ILLEGAL_OP_TRAP_EN
        dec.illegal = 1'b1;
`else
        dec.illegal = 1'b0;
`endif
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    case (state_q)
      IDLE, ISSUE: begin
        if (accept) begin
          if (!is_mult || MULT_LATENCY == 1) begin
            word_d  = dec;
            state_d = ISSUE;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = MULT_WAIT;
          end
        end else if (state_q == ISSUE && out_ready) begin
          state_d = IDLE;
        end
      end
      MULT_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // last stall cycle: the MULT word becomes visible next cycle
        if (cnt_q == 4'd1) begin
          word_d  = mult_word;
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
    end
  end

  assign alu_func      = word_q.alu_func;
  assign pc_rel_branch = word_q.pc_rel_branch;
  assign reg_write     = word_q.reg_write;
  assign immediate     = word_q.immediate;
  assign mult          = word_q.mult;
  assign read_in       = word_q.read_in;
  assign write_out     = word_q.write_out;
  assign illegal       = word_q.illegal;

endmodule

// File: tb/tb_pipelined_decoder.sv
// Bench for pipelined_decoder: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_pipelined_decoder;

  localparam int L = 3;

  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_ADDI = 6'd3;
  localparam logic [5:0] OP_SUBI = 6'd4;
  localparam logic [5:0] OP_BEQ  = 6'd5;
  localparam logic [5:0] OP_BNQ  = 6'd6;
  localparam logic [5:0] OP_JMP  = 6'd7;
  localparam logic [5:0] OP_MULT = 6'd8;
  localparam logic [5:0] OP_STIN = 6'd9;
  localparam logic [5:0] OP_LOUT = 6'd10;
  localparam logic [2:0] RADD    = 3'd2;
  localparam logic [2:0] RSUB    = 3'd3;

`ifdef ILLEGAL_OP_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] opcode;
  logic       ZF;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] alu_func;
  logic       pc_rel_branch;
  logic       reg_write;
  logic       immediate;
  logic       mult;
  logic       read_in;
  logic       write_out;
  logic       illegal;

  int total = 0;
  int bad   = 0;

  pipelined_decoder #(
    .OPCODE_W    (6),
    .ALU_FUNC_W  (3),
    .MULT_LATENCY(L)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .opcode       (opcode),
    .ZF           (ZF),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .alu_func     (alu_func),
    .pc_rel_branch(pc_rel_branch),
    .reg_write    (reg_write),
    .immediate    (immediate),
    .mult         (mult),
    .read_in      (read_in),
    .write_out    (write_out),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  logic [8:0] obs;
  assign obs = {alu_func, pc_rel_branch, reg_write, immediate,
                mult, read_in, write_out, illegal};

  function automatic logic [8:0] ref_word(input logic [5:0] op,
                                          input logic zf);
    logic [2:0] alu;
    logic br, rw, im, mu, ri, wo, il;
    {alu, br, rw, im, mu, ri, wo, il} = '0;
    case (op)
      OP_ADD:  begin alu = RADD; rw = 1'b1; end
      OP_ADDI: begin alu = RADD; rw = 1'b1; im = 1'b1; end
      OP_SUB:  begin alu = RSUB; rw = 1'b1; end
      OP_SUBI: begin alu = RSUB; rw = 1'b1; im = 1'b1; end
      OP_BEQ:  br = zf;
      OP_BNQ:  br = !zf;
      OP_JMP:  br = 1'b1;
      OP_MULT: begin mu = 1'b1; rw = 1'b1; end
      OP_STIN: begin ri = 1'b1; rw = 1'b1; end
      OP_LOUT: wo = 1'b1;
      default: il = TRAP;
    endcase
    return {alu, br, rw, im, mu, ri, wo, il};
  endfunction

  task automatic drive(input logic v, input logic [5:0] op,
                       input logic zf, input logic rdy);
    in_valid  = v;
    opcode    = op;
    ZF        = zf;
    out_ready = rdy;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 6'd0, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b0 || obs !== 9'd0) begin
      bad++;
      $display("FAIL reset: valid=%b word=%h want 0/000", out_valid, obs);
    end
    adv();
    reset = 1'b0;
  endtask

  task automatic test_add_addi();
    drive(1'b1, OP_ADD, 1'b0, 1'b1);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL add_accept: rdy=%b valid=%b want 1/0", in_ready, out_valid);
    end
    adv();
    drive(1'b1, OP_ADDI, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b1 || obs !== ref_word(OP_ADD, 1'b0)) begin
      bad++;
      $display("FAIL add_word: valid=%b word=%h want 1/%h",
               out_valid, obs, ref_word(OP_ADD, 1'b0));
    end
    adv();
    drive(1'b0, 6'd0, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b1 || obs !== ref_word(OP_ADDI, 1'b0)) begin
      bad++;
      $display("FAIL addi_word: valid=%b word=%h want 1/%h",
               out_valid, obs, ref_word(OP_ADDI, 1'b0));
    end
    adv();
    drive(1'b0, 6'd0, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL add_drain: valid=%b want 0", out_valid);
    end
    adv();
  endtask

  task automatic test_branch();
    logic [5:0] ops [4] = '{OP_BEQ, OP_BEQ, OP_BNQ, OP_BNQ};
    logic       zfs [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic       exb [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) drive(1'b1, ops[k], zfs[k], 1'b1);
      else       drive(1'b0, 6'd0, 1'b0, 1'b1);
      if (k > 0) begin
        total++;
        if (out_valid !== 1'b1 || pc_rel_branch !== exb[k-1]) begin
          bad++;
          $display("FAIL branch_%0d: valid=%b br=%b want 1/%b",
                   k - 1, out_valid, pc_rel_branch, exb[k-1]);
        end
      end
      adv();
    end
    drive(1'b1, OP_BEQ, 1'b1, 1'b0);
    adv();
    for (int j = 0; j < 3; j++) begin
      drive(1'b0, 6'd0, j[0], 1'b0);
      total++;
      if (out_valid !== 1'b1 || pc_rel_branch !== 1'b1) begin
        bad++;
        $display("FAIL zf_hold_%0d: valid=%b br=%b want 1/1",
                 j, out_valid, pc_rel_branch);
      end
      adv();
    end
    drive(1'b0, 6'd0, 1'b0, 1'b1);
    adv();
  endtask

  task automatic test_mult_latency();
    drive(1'b1, OP_MULT, 1'b0, 1'b1);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL mult_accept: rdy=%b want 1", in_ready);
    end
    adv();
    for (int c = 1; c < L; c++) begin
      drive(1'b1, OP_ADD, 1'b0, 1'b1);
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL mult_stall_t+%0d: rdy=%b valid=%b want 0/0",
                 c, in_ready, out_valid);
      end
      adv();
    end
    drive(1'b0, 6'd0, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b1 || obs !== ref_word(OP_MULT, 1'b0)) begin
      bad++;
      $display("FAIL mult_word: valid=%b word=%h want 1/%h",
               out_valid, obs, ref_word(OP_MULT, 1'b0));
    end
    adv();
    drive(1'b0, 6'd0, 1'b0, 1'b1);
    adv();
  endtask

  task automatic test_stall();
    drive(1'b1, OP_SUB, 1'b0, 1'b0);
    adv();
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, OP_STIN, 1'b0, 1'b0);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          obs !== ref_word(OP_SUB, 1'b0)) begin
        bad++;
        $display("FAIL stall_hold_%0d: valid=%b rdy=%b word=%h want 1/0/%h",
                 c, out_valid, in_ready, obs, ref_word(OP_SUB, 1'b0));
      end
      adv();
    end
    drive(1'b1, OP_STIN, 1'b0, 1'b1);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_release: rdy=%b want 1", in_ready);
    end
    adv();
    drive(1'b0, 6'd0, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b1 || obs !== ref_word(OP_STIN, 1'b0)) begin
      bad++;
      $display("FAIL stin_word: valid=%b word=%h want 1/%h",
               out_valid, obs, ref_word(OP_STIN, 1'b0));
    end
    adv();
    drive(1'b0, 6'd0, 1'b0, 1'b1);
    adv();
  endtask

  task automatic test_reset_mult_wait();
    drive(1'b1, OP_SUB, 1'b0, 1'b1);
    adv();
    drive(1'b1, OP_MULT, 1'b0, 1'b1);
    adv();
    drive(1'b0, 6'd0, 1'b0, 1'b1);
    #1 reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || obs !== 9'd0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_async: valid=%b word=%h rdy=%b want 0/000/1",
               out_valid, obs, in_ready);
    end
    adv();
    reset = 1'b0;
    for (int c = 0; c <= L; c++) begin
      drive(1'b0, 6'd0, 1'b0, 1'b1);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL reset_abort_%0d: valid=%b rdy=%b want 0/1",
                 c, out_valid, in_ready);
      end
      adv();
    end
  endtask

  task automatic test_illegal();
    drive(1'b1, 6'h3F, 1'b1, 1'b1);
    adv();
    drive(1'b0, 6'd0, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b1 || illegal !== TRAP || obs[8:1] !== 8'd0) begin
      bad++;
      $display("FAIL illegal: valid=%b ill=%b flags=%h want 1/%b/00",
               out_valid, illegal, obs[8:1], TRAP);
    end
    adv();
    drive(1'b0, 6'd0, 1'b0, 1'b1);
    adv();
  endtask

  task automatic test_random();
    bit         have = 1'b0;
    logic [8:0] held = '0;
    int         wt = 0;
    logic       v, zf, rdy, exp_rdy;
    logic [5:0] op;
    for (int i = 0; i < 400; i++) begin
      v   = 1'($urandom_range(0, 1));
      op  = ($urandom_range(0, 9) == 0) ? 6'h3F : 6'($urandom_range(0, 11));
      zf  = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 3) != 0);
      drive(v, op, zf, rdy);
      exp_rdy = (wt == 0) && (!have || rdy);
      total++;
      if (out_valid !== have || in_ready !== exp_rdy ||
          (have && obs !== held)) begin
        bad++;
        $display("FAIL rand_%0d: valid=%b rdy=%b word=%h want %b/%b/%h",
                 i, out_valid, in_ready, obs, have, exp_rdy, held);
      end
      if (wt > 0) begin
        wt--;
        if (wt == 0) begin
          have = 1'b1;
          held = ref_word(OP_MULT, 1'b0);
        end
      end else begin
        if (have && rdy) have = 1'b0;
        if (v && exp_rdy) begin
          if (op == OP_MULT && L > 1) begin
            wt   = L - 1;
            have = 1'b0;
          end else begin
            have = 1'b1;
            held = ref_word(op, zf);
          end
        end
      end
      adv();
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    opcode    = '0;
    ZF        = 1'b0;
    out_ready = 1'b0;
    adv();
    test_reset();
    test_add_addi();
    test_branch();
    test_mult_latency();
    test_stall();
    test_reset_mult_wait();
    test_illegal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
